bit8_1to2_demux_buf: RTL and testbench

//  - Buffered 1-to-2 demultiplexer: the inverse of the 8-bit 2-to-1 mux path.
//  - Steers one byte stream to out0 (sel=0) or out1 (sel=1).
//  - Each output channel has its own FIFO, so a stalled sink does not block traffic to the other channel.
//  - Sits between a single producer and two independent consumers; valid/ready handshake on all sides.

---
 rtl/bit8_1to2_demux_buf.sv | 191 +++++++++++++++++++
 tb/tb_bit8_1to2_demux_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit8_1to2_demux_buf.sv
// -----------------------------------------------------------------------------
// bit8_1to2_demux_buf
//
// Buffered 1-to-2 demultiplexer. A single producer stream is steered by in_sel
// to channel 0 or channel 1. Each channel has its own FIFO, so a stalled
// consumer on one channel never blocks traffic headed for the other.
//
// Parameters
//   WIDTH  data width in bits
//   DEPTH  entries per channel FIFO (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports
//   clk                    single clock, all state updates on posedge
//   rst_n                  synchronous active-low reset, flushes both FIFOs
//   in_data/in_sel         byte and destination channel (0 -> out0, 1 -> out1)
//   in_valid/in_ready      producer handshake; in_ready = channel in_sel not full
//   out0_data/valid/ready  channel-0 head byte and consumer handshake
//   out1_data/valid/ready  channel-1 head byte and consumer handshake
//   cnt0/cnt1              16-bit delivered-byte counters, wrap at 16'hFFFF
//
// Optional feature
//   DEMUX_CNT_EN  when defined, adds the cnt0/cnt1 ports and counter logic.
//                 When undefined, those ports and counters do not exist.
// -----------------------------------------------------------------------------
module bit8_1to2_demux_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   localparam logic [AW:0] OccFull  = AW'(DEPTH) == '0 ? {1'b1, {AW{1'b0}}} : (AW+1)'(DEPTH);
   localparam logic [AW:0] OccEmpty = '0;

   // Per-channel state, index 0 = out0, index 1 = out1.
   logic [AW-1:0]    head_q [2];
   logic [AW-1:0]    head_d [2];
   logic [AW-1:0]    tail_q [2];
   logic [AW-1:0]    tail_d [2];
   logic [AW:0]      occ_q  [2];
   logic [AW:0]      occ_d  [2];
   logic [WIDTH-1:0] mem_q  [2][DEPTH];

   logic [1:0]       full;
   logic [1:0]       out_valid;
   logic [1:0]       out_ready;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic             accept;
   logic [WIDTH-1:0] head_data [2];

   // ---------------------------------------------------------------------------
   // Status and handshake decode. Everything here depends only on registered
   // occupancy plus in_sel/in_valid, so in_ready has no path from outN_ready.
   // ---------------------------------------------------------------------------
   always_comb begin
      out_ready = {out1_ready, out0_ready};
      full      = '0;
      out_valid = '0;
      for (int c = 0; c < 2; c++) begin
         full[c]      = (occ_q[c] == OccFull);
         out_valid[c] = (occ_q[c] != OccEmpty);
      end

      // A full channel refuses even if it pops this same cycle.
      in_ready = ~full[in_sel];
      accept   = in_valid & in_ready;

      push[0] = accept & ~in_sel;
      push[1] = accept &  in_sel;

      // Pops on an empty channel are ignored.
      pop = out_valid & out_ready;
   end

   // ---------------------------------------------------------------------------
   // Next-state for pointers and occupancy. Pointers wrap naturally because
   // DEPTH is 2**AW; full/empty come from occupancy, never pointer equality.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         head_d[c] = head_q[c];
         tail_d[c] = tail_q[c];
         occ_d[c]  = occ_q[c];

         if (push[c]) begin
            tail_d[c] = tail_q[c] + AW'(1);
         end
         if (pop[c]) begin
            head_d[c] = head_q[c] + AW'(1);
         end

         unique case ({push[c], pop[c]})
            2'b10:   occ_d[c] = occ_q[c] + (AW+1)'(1);
            2'b01:   occ_d[c] = occ_q[c] - (AW+1)'(1);
            default: occ_d[c] = occ_q[c];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            head_q[c] <= '0;
            tail_q[c] <= '0;
            occ_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            head_q[c] <= head_d[c];
            tail_q[c] <= tail_d[c];
            occ_q[c]  <= occ_d[c];
         end
      end
   end

   // Storage needs no reset: a byte is only visible while occupancy covers it.
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (rst_n && push[c]) begin
            mem_q[c][tail_q[c]] <= in_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output presentation: head entry while non-empty, zero otherwise.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         head_data[c] = '0;
         if (out_valid[c]) begin
            head_data[c] = mem_q[c][head_q[c]];
         end
      end
   end

   assign out0_data  = head_data[0];
   assign out1_data  = head_data[1];
   assign out0_valid = out_valid[0];
   assign out1_valid = out_valid[1];

`ifdef DEMUX_CNT_EN
   // ---------------------------------------------------------------------------
   // Delivered-byte counters, one per channel, wrapping modulo 2**16.
   // ---------------------------------------------------------------------------
   logic [15:0] cnt_q [2];
   logic [15:0] cnt_d [2];

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         cnt_d[c] = cnt_q[c];
         if (pop[c]) begin
            cnt_d[c] = cnt_q[c] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_bit8_1to2_demux_buf.sv
// -----------------------------------------------------------------------------
// tb_bit8_1to2_demux_buf
//
// Directed bench for bit8_1to2_demux_buf: reset, routing, fill/backpressure,
// push+pop across pointer wrap, full+pop edge and mid-stream reset. With
// DEMUX_CNT_EN defined it also exercises the delivered-byte counters.
// -----------------------------------------------------------------------------
module tb_bit8_1to2_demux_buf;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out0_data;
   logic       out0_valid;
   logic       out0_ready;
   logic [7:0] out1_data;
   logic       out1_valid;
   logic       out1_ready;
`ifdef DEMUX_CNT_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   int total;
   int bad;

   bit8_1to2_demux_buf #(
      .WIDTH (8),
      .DEPTH (4),
      .AW    (2)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      drive(1'b1, 1'b0, 8'hFF);

      // Reset held two cycles with a pending push.
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out0_valid", out0_valid, 0);
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_out0_data", out0_data, 0);
      chk("rst_out1_data", out1_data, 0);
`ifdef DEMUX_CNT_EN
      chk("rst_cnt0", cnt0, 0);
`endif
      drive(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      tick();
      chk("rst_no_push", out0_valid, 0);

      // Routing.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      drive(1'b1, 1'b0, 8'hAA);
      chk("route_in_ready", in_ready, 1);
      tick();
      chk("route_out0_valid", out0_valid, 1);
      chk("route_out0_data", out0_data, 8'hAA);
      chk("route_out1_idle", out1_valid, 0);
      drive(1'b1, 1'b1, 8'h55);
      tick();
      chk("route_out0_popped", out0_valid, 0);
      chk("route_out1_valid", out1_valid, 1);
      chk("route_out1_data", out1_data, 8'h55);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("route_out1_popped", out1_valid, 0);

      // Fill channel 0 under backpressure.
      out0_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         chk("fill_in_ready", in_ready, 1);
         tick();
         chk("fill_head", out0_data, 8'h01);
      end
      drive(1'b1, 1'b0, 8'h99);
      chk("full_in_ready_sel0", in_ready, 0);
      tick();
      drive(1'b1, 1'b1, 8'hF0);
      chk("full_in_ready_sel1", in_ready, 1);
      tick();
      chk("other_out1_valid", out1_valid, 1);
      chk("other_out1_data", out1_data, 8'hF0);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("other_out1_popped", out1_valid, 0);
      out0_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", out0_valid, 1);
         chk("drain_data", out0_data, 32'(i));
         tick();
      end
      chk("drain_empty", out0_valid, 0);

      // Two bytes resident, then push+pop every cycle across the pointer wrap.
      out0_ready = 1'b0;
      drive(1'b1, 1'b0, 8'h10);
      tick();
      drive(1'b1, 1'b0, 8'h11);
      tick();
      out0_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 8'(8'h12 + i));
         chk("simul_in_ready", in_ready, 1);
         chk("simul_head", out0_data, 32'(8'h10 + i));
         tick();
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("simul_rem0", out0_data, 8'h16);
      tick();
      chk("simul_rem1", out0_data, 8'h17);
      tick();
      chk("simul_occ2", out0_valid, 0);

      // Full channel popping while a push is offered.
      out0_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'(8'h20 + i));
         tick();
      end
      out0_ready = 1'b1;
      drive(1'b1, 1'b0, 8'h77);
      chk("fullpop_refused", in_ready, 0);
      tick();
      chk("fullpop_head", out0_data, 8'h21);
      chk("fullpop_ready_next", in_ready, 1);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      chk("fullpop_seq22", out0_data, 8'h22);
      tick();
      chk("fullpop_seq23", out0_data, 8'h23);
      tick();
      chk("fullpop_seq77", out0_data, 8'h77);
      chk("fullpop_valid77", out0_valid, 1);
      tick();
      chk("fullpop_empty", out0_valid, 0);

      // Reset in the middle of a stream on channel 1.
      out1_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'(8'h31 + i));
         tick();
      end
      drive(1'b0, 1'b0, 8'h00);
      chk("mid_pre_valid", out1_valid, 1);
      chk("mid_pre_data", out1_data, 8'h31);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_out1_valid", out1_valid, 0);
      chk("mid_out1_data", out1_data, 0);
      chk("mid_in_ready", in_ready, 1);
      out1_ready = 1'b1;
      tick();
      chk("mid_nothing_delivered", out1_valid, 0);
`ifdef DEMUX_CNT_EN
      chk("mid_cnt1", cnt1, 0);
      chk("mid_cnt0", cnt0, 0);

      // 65537 pops on channel 0 wraps the counter to 1.
      out0_ready = 1'b1;
      drive(1'b1, 1'b0, 8'h5A);
      for (int i = 0; i < 65537; i++) begin
         tick();
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("cnt0_wrap", cnt0, 1);
      chk("cnt1_idle", cnt1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
